paddle_mover: RTL and testbench



---
 rtl/paddle_mover.sv | 140 ++++++++++++++
 tb/tb_paddle_mover.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_mover.sv
// Paddle position register with per-frame stepping, hold-to-accelerate speed ramp
// and clamping to the playfield so the centre never leaves [Y_MIN, Y_MAX].
module paddle_mover #(
    parameter int SCREEN_H  = 480,
    parameter int PADDLE_H  = 80,
    parameter int V_MIN     = 1,
    parameter int V_MAX     = 4,
    parameter int ACC_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tick,
    input  logic        center,
    input  logic        p,
    input  logic        m,
    output logic [10:0] py,
    output logic        moving,
    output logic        dir,
    output logic        at_min,
    output logic        at_max
);

    localparam int Y_MIN = PADDLE_H / 2;
    localparam int Y_MAX = SCREEN_H - 1 - PADDLE_H / 2;
    localparam int Y_CTR = SCREEN_H / 2;
    localparam int SW    = $clog2(V_MAX + 1);
    localparam int CW    = $clog2(ACC_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_P = 2'd1,
        MOVE_M = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   speed_q, speed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [10:0]     py_q, py_d;
    logic            p_q, m_q;
    logic            moving_q, moving_d;
    logic            dir_q, dir_d;
    logic            at_min_q, at_min_d;
    logic            at_max_q, at_max_d;

    logic            req_plus, req_minus;
    logic [SW:0]     speed_inc;
    logic [11:0]     step;
    logic [11:0]     sum_p;

    assign req_plus  = ~p_q &  m_q;
    assign req_minus =  p_q & ~m_q;
    assign speed_inc = {1'b0, speed_q} + (SW+1)'(1);

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        py_d    = py_q;
        step    = '0;
        sum_p   = '0;

        if (!en) begin
            state_d = IDLE;
            speed_d = SW'(V_MIN);
            cnt_d   = '0;
        end else if (center) begin
            state_d = IDLE;
            speed_d = SW'(V_MIN);
            cnt_d   = '0;
            py_d    = 11'(Y_CTR);
        end else if (tick) begin
            if (!req_plus && !req_minus) begin
                state_d = IDLE;
                speed_d = SW'(V_MIN);
                cnt_d   = '0;
            end else begin
                state_d = req_plus ? MOVE_P : MOVE_M;
                // A change of direction (including starting from rest) restarts the ramp.
                if (state_q != state_d) begin
                    speed_d = SW'(V_MIN);
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(ACC_TICKS)) begin
                    speed_d = (speed_inc > (SW+1)'(V_MAX)) ? SW'(V_MAX) : speed_inc[SW-1:0];
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end

                step  = 12'(speed_d);
                sum_p = {1'b0, py_q} + step;
                // Minus side compares before subtracting so the unsigned value never wraps.
                if (req_plus)
                    py_d = (sum_p > 12'(Y_MAX)) ? 11'(Y_MAX) : sum_p[10:0];
                else
                    py_d = ({1'b0, py_q} < 12'(Y_MIN) + step) ? 11'(Y_MIN)
                                                              : py_q - step[10:0];
            end
        end

        moving_d = (state_d != IDLE);
        dir_d    = (state_d == MOVE_P);
        at_min_d = (py_d == 11'(Y_MIN));
        at_max_d = (py_d == 11'(Y_MAX));
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            speed_q  <= SW'(V_MIN);
            cnt_q    <= '0;
            py_q     <= 11'(Y_CTR);
            p_q      <= 1'b1;
            m_q      <= 1'b1;
            moving_q <= 1'b0;
            dir_q    <= 1'b0;
            at_min_q <= 1'b0;
            at_max_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            py_q     <= py_d;
            p_q      <= p;
            m_q      <= m;
            moving_q <= moving_d;
            dir_q    <= dir_d;
            at_min_q <= at_min_d;
            at_max_q <= at_max_d;
        end
    end

    assign py     = py_q;
    assign moving = moving_q;
    assign dir    = dir_q;
    assign at_min = at_min_q;
    assign at_max = at_max_q;

endmodule

// File: tb/tb_paddle_mover.sv
// Directed bench for paddle_mover: ramp, clamps, stop/reversal, control priority, async reset.
module tb_paddle_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic        center;
    logic        p;
    logic        m;
    logic [10:0] py;
    logic        moving;
    logic        dir;
    logic        at_min;
    logic        at_max;

    int n_checks = 0;
    int n_fail   = 0;

    paddle_mover dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tick   (tick),
        .center (center),
        .p      (p),
        .m      (m),
        .py     (py),
        .moving (moving),
        .dir    (dir),
        .at_min (at_min),
        .at_max (at_max)
    );

    always #5 clk = ~clk;

    // One tick pulse spanning exactly one rising edge; outputs are sampled on the next falling edge.
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Change the buttons and let one edge pass so p_q/m_q see them before the next tick.
    task automatic set_buttons(input logic pv, input logic mv);
        p = pv;
        m = mv;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b0; center = 1'b0; p = 1'b1; m = 1'b1;
        #1;
        n_checks++; if (py !== 11'd240) begin n_fail++; $display("FAIL reset_py got %0d want 240", py); end
        n_checks++; if ({moving, dir, at_min, at_max} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {moving, dir, at_min, at_max});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic [10:0] want [4] = '{11'd248, 11'd264, 11'd288, 11'd320};
        set_buttons(1'b0, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            do_tick();
            if (i % 8 == 0) begin
                n_checks++; if (py !== want[i/8-1]) begin
                    n_fail++; $display("FAIL ramp_tick%0d got %0d want %0d", i, py, want[i/8-1]);
                end
            end
        end
        n_checks++; if ({moving, dir} !== 2'b11) begin
            n_fail++; $display("FAIL ramp_status got moving,dir=%b want 11", {moving, dir});
        end
    endtask

    task automatic test_upper_clamp();
        logic [10:0] max_seen = '0;
        for (int i = 0; i < 100; i++) begin
            do_tick();
            if (py > max_seen) max_seen = py;
        end
        n_checks++; if (max_seen !== 11'd439) begin n_fail++; $display("FAIL upper_max_seen got %0d want 439", max_seen); end
        n_checks++; if (py !== 11'd439) begin n_fail++; $display("FAIL upper_py got %0d want 439", py); end
        n_checks++; if ({at_max, at_min, moving} !== 3'b101) begin
            n_fail++; $display("FAIL upper_flags got at_max,at_min,moving=%b want 101", {at_max, at_min, moving});
        end
    endtask

    task automatic test_lower_clamp();
        set_buttons(1'b1, 1'b0);
        // 24 ticks: 8 at speed 1, 8 at 2, 8 at 3 -> 439 - 48 = 391, now at speed 4.
        repeat (24) do_tick();
        n_checks++; if (py !== 11'd391) begin n_fail++; $display("FAIL lower_ramp got %0d want 391", py); end
        repeat (87) do_tick();
        n_checks++; if (py !== 11'd43) begin n_fail++; $display("FAIL lower_pre got %0d want 43", py); end
        n_checks++; if (at_min !== 1'b0) begin n_fail++; $display("FAIL lower_pre_at_min got %b want 0", at_min); end
        do_tick();
        n_checks++; if (py !== 11'd40) begin n_fail++; $display("FAIL lower_clamp got %0d want 40", py); end
        n_checks++; if (at_min !== 1'b1) begin n_fail++; $display("FAIL lower_at_min got %b want 1", at_min); end
        repeat (3) do_tick();
        n_checks++; if ({py, moving, dir} !== {11'd40, 2'b10}) begin
            n_fail++; $display("FAIL lower_hold got py=%0d moving,dir=%b want 40 10", py, {moving, dir});
        end
    endtask

    task automatic test_stop_reversal();
        center = 1'b1; @(negedge clk); center = 1'b0;
        set_buttons(1'b1, 1'b1);
        repeat (3) do_tick();
        n_checks++; if ({py, moving} !== {11'd240, 1'b0}) begin
            n_fail++; $display("FAIL stop_both_high got py=%0d moving=%b want 240 0", py, moving);
        end
        set_buttons(1'b0, 1'b0);
        repeat (3) do_tick();
        n_checks++; if ({py, moving} !== {11'd240, 1'b0}) begin
            n_fail++; $display("FAIL stop_both_low got py=%0d moving=%b want 240 0", py, moving);
        end
        set_buttons(1'b0, 1'b1);
        repeat (12) do_tick();
        n_checks++; if (py !== 11'd256) begin n_fail++; $display("FAIL rev_plus12 got %0d want 256", py); end
        set_buttons(1'b1, 1'b0);
        do_tick();
        n_checks++; if ({py, moving, dir} !== {11'd255, 2'b10}) begin
            n_fail++; $display("FAIL rev_first_minus got py=%0d moving,dir=%b want 255 10", py, {moving, dir});
        end
        do_tick();
        n_checks++; if (py !== 11'd254) begin n_fail++; $display("FAIL rev_second_minus got %0d want 254", py); end
    endtask

    task automatic test_priority();
        center = 1'b1;
        do_tick();
        center = 1'b0;
        n_checks++; if ({py, moving} !== {11'd240, 1'b0}) begin
            n_fail++; $display("FAIL center_wins got py=%0d moving=%b want 240 0", py, moving);
        end
        set_buttons(1'b0, 1'b1);
        repeat (10) do_tick();
        n_checks++; if (py !== 11'd252) begin n_fail++; $display("FAIL prio_plus10 got %0d want 252", py); end
        en = 1'b0;
        repeat (3) do_tick();
        n_checks++; if ({py, moving} !== {11'd252, 1'b0}) begin
            n_fail++; $display("FAIL en_low_hold got py=%0d moving=%b want 252 0", py, moving);
        end
        en = 1'b1;
        do_tick();
        n_checks++; if ({py, moving, dir} !== {11'd253, 2'b11}) begin
            n_fail++; $display("FAIL reenable_vmin got py=%0d moving,dir=%b want 253 11", py, {moving, dir});
        end
    endtask

    task automatic test_reset_mid_move();
        repeat (12) do_tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({py, moving, at_min, at_max} !== {11'd240, 3'b000}) begin
            n_fail++; $display("FAIL async_reset got py=%0d moving,at_min,at_max=%b want 240 000",
                               py, {moving, at_min, at_max});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_upper_clamp();
        test_lower_clamp();
        test_stop_reversal();
        test_priority();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
